// File: rtl/ff_meta_pkg.sv
// Shared types for the flop-based cache metadata array: flush FSM states and
// the default per-set way-data vector.
package ff_meta_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    localparam int DEF_S_INDEX  = 4;
    localparam int DEF_WIDTH    = 1;
    localparam int DEF_NUM_WAYS = 4;

    // All ways of one set for the default geometry, packed [way][bit].
    typedef logic [DEF_NUM_WAYS-1:0][DEF_WIDTH-1:0] way_data_t;

    function automatic int num_sets(input int s_index);
        return 1 << s_index;
    endfunction

endpackage

// File: rtl/ff_meta_flush_ctrl.sv
// Flush-all engine: walks every set once, one set per clock, then pulses
// flush_done. The state is exported for debug and for the top's write gating.
module ff_meta_flush_ctrl
    import ff_meta_pkg::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               clr_en,
    output logic [S_INDEX-1:0] clr_set,
    output flush_state_e       state
);

    localparam int NUM_SETS = num_sets(S_INDEX);
    localparam logic [S_INDEX:0] LAST_SET = (S_INDEX+1)'(NUM_SETS - 1);

    flush_state_e     state_q, state_d;
    logic [S_INDEX:0] cnt_q, cnt_d;
    logic             flush_done_q, flush_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                // The counter stops at the last set; it never wraps past it.
                if (cnt_q == LAST_SET) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    flush_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == FLUSH);
    assign clr_en     = (state_q == FLUSH);
    assign clr_set    = cnt_q[S_INDEX-1:0];
    assign flush_done = flush_done_q;
    assign state      = state_q;

endmodule

// File: rtl/ff_meta_array.sv
// Multi-way valid/tag/LRU metadata array with a registered write port, a registered
// read port, single-set invalidate and flush-all. Optional write-to-read forwarding
// is enabled by defining FF_META_ARRAY_BYPASS_EN.
module ff_meta_array
    import ff_meta_pkg::*;
#(
    parameter int S_INDEX  = 4,
    parameter int WIDTH    = 1,
    parameter int NUM_WAYS = 4
) (
    input  logic                               clk0,
    input  logic                               rst0_n,
    input  logic                               csb0,
    input  logic                               web0,
    input  logic [NUM_WAYS-1:0]                wmask0,
    input  logic [S_INDEX-1:0]                 addr0,
    input  logic [S_INDEX-1:0]                 addr1,
    input  logic [NUM_WAYS-1:0][WIDTH-1:0]     din0,
    output logic [NUM_WAYS-1:0][WIDTH-1:0]     dout1,
    input  logic                               inv_en,
    input  logic [S_INDEX-1:0]                 inv_set,
    input  logic                               flush_req,
    output logic                               busy,
    output logic                               flush_done
);

    localparam int NUM_SETS = num_sets(S_INDEX);

    typedef logic [NUM_WAYS-1:0][WIDTH-1:0] set_data_t;

    logic                web0_q, web0_d;
    logic [NUM_WAYS-1:0] wmask_q, wmask_d;
    logic [S_INDEX-1:0]  addr0_q, addr0_d;
    logic [S_INDEX-1:0]  addr1_q, addr1_d;
    set_data_t           din_q, din_d;
    set_data_t           mem_q [NUM_SETS];
    set_data_t           mem_d [NUM_SETS];

    logic                clr_en;
    logic [S_INDEX-1:0]  clr_set;
    flush_state_e        flush_state;
    logic                wr_commit;
    set_data_t           rd_data;

    ff_meta_flush_ctrl #(
        .S_INDEX (S_INDEX)
    ) u_flush_ctrl (
        .clk        (clk0),
        .rst_n      (rst0_n),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .clr_en     (clr_en),
        .clr_set    (clr_set),
        .state      (flush_state)
    );

    // Deselected cycles cancel any pending write but keep the read address,
    // so dout1 keeps tracking the last-read set.
    always_comb begin
        web0_d  = 1'b1;
        wmask_d = wmask_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        din_d   = din_q;
        if (!csb0) begin
            web0_d  = web0;
            wmask_d = wmask0;
            addr0_d = addr0;
            addr1_d = addr1;
            din_d   = din0;
        end
    end

    // Writes landing during a flush are dropped outright, not replayed later.
    assign wr_commit = !web0_q && (flush_state == IDLE);

    // Applied lowest priority first so flush clear beats invalidate beats write.
    always_comb begin
        mem_d = mem_q;
        if (wr_commit) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wmask_q[w]) begin
                    mem_d[addr0_q][w] = din_q[w];
                end
            end
        end
        if (inv_en) begin
            mem_d[inv_set] = '0;
        end
        if (clr_en) begin
            mem_d[clr_set] = '0;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            web0_q  <= 1'b1;
            wmask_q <= '0;
            addr0_q <= '0;
            addr1_q <= '0;
            din_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                mem_q[s] <= '0;
            end
        end else begin
            web0_q  <= web0_d;
            wmask_q <= wmask_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            din_q   <= din_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd_data = mem_q[addr1_q];
`ifdef FF_META_ARRAY_BYPASS_EN
        // Forward the pending write so a same-cycle read sees the new ways.
        if (!web0_q && (addr0_q == addr1_q) && (flush_state == IDLE)) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wmask_q[w]) begin
                    rd_data[w] = din_q[w];
                end
            end
        end
`endif
    end

    assign dout1 = rd_data;

endmodule
